// File: rtl/axi_image_loader.sv
// rtl/axi_image_loader.sv - AXI4-Lite loaded image buffer with commit/ack handover to a pixel-reading core
module axi_image_loader #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int PIXEL_WIDTH    = 8,
    parameter int NUM_PIXELS     = 256
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [AXI_ADDR_WIDTH-1:0]     AWADDR,
    input  logic [2:0]                    AWPROT,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]     ARADDR,
    input  logic [2:0]                    ARPROT,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RVALID,
    input  logic                          RREADY,
    input  logic [$clog2(NUM_PIXELS)-1:0] PIX_ADDR,
    output logic [PIXEL_WIDTH-1:0]        PIX_DATA,
    output logic                          IMAGE_VALID,
    input  logic                          IMAGE_ACK
);
    localparam int BYTES     = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB  = $clog2(BYTES);
    localparam int PPW       = AXI_DATA_WIDTH / PIXEL_WIDTH;
    localparam int PPW_LSB   = $clog2(PPW);
    localparam int NUM_WORDS = NUM_PIXELS / PPW;
    localparam int IDX_W     = AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int PA_W      = $clog2(NUM_PIXELS);
    localparam int WA_W      = PA_W - PPW_LSB;
    localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(NUM_WORDS);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [AXI_DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [AXI_DATA_WIDTH-1:0] mem_d [NUM_WORDS];
    logic                      ready_en_q, ready_en_d;
    logic                      aw_full_q, aw_full_d;
    logic [IDX_W-1:0]          aw_idx_q, aw_idx_d;
    logic                      w_full_q, w_full_d;
    logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [BYTES-1:0]          w_strb_q, w_strb_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      rvalid_q, rvalid_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      image_valid_q, image_valid_d;
    logic [PIXEL_WIDTH-1:0]    pix_data_q, pix_data_d;
    logic [AXI_DATA_WIDTH-1:0] pix_word;
    logic [PPW_LSB-1:0]        pix_lane;
    logic [IDX_W-1:0]          ar_idx;
    logic                      wr_fire, ar_fire;
    logic                      unused_ok;

    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

    // ready_en_q holds every ready low during reset and for the edge that leaves it
    assign AWREADY     = ready_en_q && !aw_full_q;
    assign WREADY      = ready_en_q && !w_full_q;
    assign ARREADY     = ready_en_q && !rvalid_q;
    assign BVALID      = bvalid_q;
    assign BRESP       = bresp_q;
    assign RVALID      = rvalid_q;
    assign RRESP       = rresp_q;
    assign RDATA       = rdata_q;
    assign IMAGE_VALID = image_valid_q;
    assign PIX_DATA    = pix_data_q;

    assign wr_fire = aw_full_q && w_full_q && (!bvalid_q || BREADY);
    assign ar_fire = ARVALID && ARREADY;
    assign ar_idx  = ARADDR[AXI_ADDR_WIDTH-1:ADDR_LSB];

    always_comb begin
        ready_en_d = 1'b1;
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        if (wr_fire) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (AWVALID && AWREADY) begin
            aw_full_d = 1'b1;
            aw_idx_d  = AWADDR[AXI_ADDR_WIDTH-1:ADDR_LSB];
        end
        if (WVALID && WREADY) begin
            w_full_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end
    end

    always_comb begin
        mem_d         = mem_q;
        image_valid_d = image_valid_q;
        bvalid_d      = bvalid_q && !BREADY;
        bresp_d       = bresp_q;
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = OKAY;
            if (aw_idx_q < CTRL_IDX) begin
                if (image_valid_q) begin
                    bresp_d = SLVERR;
                end else begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (w_strb_q[b]) begin
                            mem_d[aw_idx_q[WA_W-1:0]][b*8 +: 8] = w_data_q[b*8 +: 8];
                        end
                    end
                end
            end else if (aw_idx_q == CTRL_IDX) begin
                if (w_strb_q[0]) begin
                    if (w_data_q[1]) begin
                        if (image_valid_q) begin
                            bresp_d = SLVERR;
                        end else begin
                            for (int w = 0; w < NUM_WORDS; w++) begin
                                mem_d[w] = '0;
                            end
                        end
                    end
                    if (w_data_q[0] && !image_valid_q) begin
                        image_valid_d = 1'b1;
                    end
                end
            end else begin
                bresp_d = SLVERR;
            end
        end
        // An acknowledge overrides a commit landing on the same edge
        if (IMAGE_ACK) begin
            image_valid_d = 1'b0;
        end
    end

    always_comb begin
        rvalid_d = rvalid_q && !RREADY;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (ar_fire) begin
            rvalid_d = 1'b1;
            rresp_d  = OKAY;
            rdata_d  = '0;
            if (ar_idx < CTRL_IDX) begin
                rdata_d = mem_q[ar_idx[WA_W-1:0]];
            end else if (ar_idx == CTRL_IDX) begin
                rdata_d[0] = image_valid_q;
            end else begin
                rresp_d = SLVERR;
            end
        end
    end

    always_comb begin
        pix_lane   = PIX_ADDR[PPW_LSB-1:0];
        pix_word   = mem_q[PIX_ADDR[PA_W-1:PPW_LSB]];
        pix_data_d = pix_word[int'(pix_lane)*PIXEL_WIDTH +: PIXEL_WIDTH];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            ready_en_q    <= 1'b0;
            aw_full_q     <= 1'b0;
            aw_idx_q      <= '0;
            w_full_q      <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            bvalid_q      <= 1'b0;
            bresp_q       <= OKAY;
            rvalid_q      <= 1'b0;
            rresp_q       <= OKAY;
            rdata_q       <= '0;
            image_valid_q <= 1'b0;
            pix_data_q    <= '0;
        end else begin
            mem_q         <= mem_d;
            ready_en_q    <= ready_en_d;
            aw_full_q     <= aw_full_d;
            aw_idx_q      <= aw_idx_d;
            w_full_q      <= w_full_d;
            w_data_q      <= w_data_d;
            w_strb_q      <= w_strb_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            rvalid_q      <= rvalid_d;
            rresp_q       <= rresp_d;
            rdata_q       <= rdata_d;
            image_valid_q <= image_valid_d;
            pix_data_q    <= pix_data_d;
        end
    end
endmodule

// File: tb/tb_axi_image_loader.sv
// tb/tb_axi_image_loader.sv - self-checking bench for axi_image_loader against a pixel-level model
module tb_axi_image_loader;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [11:0] AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic [7:0]  PIX_ADDR, PIX_DATA;
    logic        IMAGE_VALID, IMAGE_ACK;

    axi_image_loader dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .PIX_ADDR(PIX_ADDR), .PIX_DATA(PIX_DATA),
        .IMAGE_VALID(IMAGE_VALID), .IMAGE_ACK(IMAGE_ACK)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    logic [7:0] mpix [256];
    logic       mvalid;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          gap;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out", nm);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) mpix[i] = 8'h00;
        mvalid = 1'b0;
    endfunction

    function automatic logic [31:0] mword(input int idx);
        if (idx < 64) return {mpix[idx*4+3], mpix[idx*4+2], mpix[idx*4+1], mpix[idx*4]};
        if (idx == 64) return {31'b0, mvalid};
        return 32'h0;
    endfunction

    function automatic logic [1:0] mwrite(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r;
        r = 2'b00;
        if (idx < 64) begin
            if (mvalid) r = 2'b10;
            else for (int b = 0; b < 4; b++) if (s[b]) mpix[idx*4+b] = d[b*8 +: 8];
        end else if (idx == 64) begin
            if (s[0]) begin
                if (d[1]) begin
                    if (mvalid) r = 2'b10;
                    else for (int i = 0; i < 256; i++) mpix[i] = 8'h00;
                end
                if (d[0]) mvalid = 1'b1;
            end
        end else begin
            r = 2'b10;
        end
        return r;
    endfunction

    task automatic aw_hs(input logic [11:0] a);
        int n = 0;
        AWADDR = a; AWVALID = 1'b1;
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) timeout("awready");
        @(negedge ACLK);
        AWVALID = 1'b0;
    endtask

    task automatic w_hs(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) timeout("wready");
        @(negedge ACLK);
        WVALID = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int gap, output logic [1:0] resp);
        int n = 0;
        aw_hs(a);
        repeat (gap) @(negedge ACLK);
        w_hs(d, s);
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) timeout("bvalid");
        resp = BRESP;
        @(negedge ACLK);
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        ARADDR = a; ARVALID = 1'b1;
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) timeout("arready");
        @(negedge ACLK);
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) timeout("rvalid");
        d = RDATA; r = RRESP;
        @(negedge ACLK);
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("rst_awready", AWREADY, 0); chk("rst_wready", WREADY, 0);
        chk("rst_arready", ARREADY, 0); chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);   chk("rst_image_valid", IMAGE_VALID, 0);
        chk("rst_pix_data", PIX_DATA, 0); chk("rst_rdata", RDATA, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("post_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        model_clear();
    endtask

    task automatic pix_chk(input int p);
        PIX_ADDR = 8'(p);
        @(negedge ACLK);
        chk($sformatf("pix[%0d]", p), PIX_DATA, mpix[p]);
    endtask

    logic [1:0]  resp, rr;
    logic [31:0] rd;
    logic [1:0]  bq [2];
    int          nresp;
    logic        sawb;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{12'h004, 32'hDDCCBBAA, 4'hF, 3, 2'b00, 32'hDDCCBBAA, 2'b00};
        tbl[1] = '{12'h004, 32'h11223344, 4'h5, 0, 2'b00, 32'hDD22BB44, 2'b00};
        tbl[2] = '{12'h104, 32'hCAFEF00D, 4'hF, 1, 2'b10, 32'h00000000, 2'b10};
        tbl[3] = '{12'h0FC, 32'h12345678, 4'h8, 2, 2'b00, 32'h12000000, 2'b00};
        tbl[4] = '{12'h200, 32'hFFFFFFFF, 4'hF, 0, 2'b10, 32'h00000000, 2'b10};
        tbl[5] = '{12'h100, 32'h00000000, 4'hF, 0, 2'b00, 32'h00000000, 2'b00};
        tbl[6] = '{12'h100, 32'h00000001, 4'hE, 0, 2'b00, 32'h00000000, 2'b00};

        ARESET = 1'b1; AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
        AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
        WDATA = '0; WSTRB = '0; PIX_ADDR = '0; IMAGE_ACK = 0;
        @(negedge ACLK);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].gap, resp);
            void'(mwrite(int'(tbl[i].addr >> 2), tbl[i].data, tbl[i].strb));
            chk($sformatf("tbl%0d_bresp", i), resp, tbl[i].exp_bresp);
            do_read(tbl[i].addr, rd, rr);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_rresp", i), rr, tbl[i].exp_rresp);
        end
        PIX_ADDR = 8'd4; @(negedge ACLK); chk("pix4", PIX_DATA, 8'h44);
        PIX_ADDR = 8'd5; @(negedge ACLK); chk("pix5", PIX_DATA, 8'hBB);
        PIX_ADDR = 8'd6; @(negedge ACLK); chk("pix6", PIX_DATA, 8'h22);
        PIX_ADDR = 8'd7; @(negedge ACLK); chk("pix7", PIX_DATA, 8'hDD);

        // commit, locked writes, refused clear, acknowledge
        do_write(12'h100, 32'h1, 4'hF, 0, resp); void'(mwrite(64, 32'h1, 4'hF));
        chk("commit_bresp", resp, 2'b00); chk("commit_valid", IMAGE_VALID, 1);
        do_write(12'h004, 32'hFFFFFFFF, 4'hF, 0, resp); chk("locked_bresp", resp, 2'b10);
        do_write(12'h100, 32'h2, 4'hF, 0, resp); chk("locked_clear_bresp", resp, 2'b10);
        do_read(12'h004, rd, rr); chk("locked_word1", rd, 32'hDD22BB44);
        do_read(12'h100, rd, rr); chk("ctrl_read_valid", rd, 32'h1);
        IMAGE_ACK = 1'b1; @(negedge ACLK); IMAGE_ACK = 1'b0; mvalid = 1'b0;
        chk("ack_clears_valid", IMAGE_VALID, 0);

        do_write(12'h100, 32'h2, 4'hF, 0, resp); void'(mwrite(64, 32'h2, 4'hF));
        chk("clear_bresp", resp, 2'b00);
        for (int w = 0; w < 64; w++) begin
            do_read(12'(w * 4), rd, rr);
            chk($sformatf("cleared_word%0d", w), rd, 32'h0);
        end

        // commit and acknowledge meeting on the same edge: acknowledge wins
        AWADDR = 12'h100; AWVALID = 1; WDATA = 32'h1; WSTRB = 4'hF; WVALID = 1;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0; IMAGE_ACK = 1;
        @(negedge ACLK);
        IMAGE_ACK = 0;
        chk("ack_vs_commit_valid", IMAGE_VALID, 0);
        chk("ack_vs_commit_b", {BVALID, BRESP}, 3'b100);
        @(negedge ACLK);

        // back-to-back writes against a stalled response channel
        BREADY = 0;
        AWADDR = 12'h008; WDATA = 32'h5A5A1234; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        @(negedge ACLK);
        AWADDR = 12'h104; WDATA = 32'h0BAD0BAD;
        nresp = 0;
        while (!(AWREADY && WREADY) && nresp < 20) begin @(negedge ACLK); nresp++; end
        if (nresp >= 20) timeout("second_hs");
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        void'(mwrite(2, 32'h5A5A1234, 4'hF));
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_ready", c), {AWREADY, WREADY, BVALID}, 3'b001);
            @(negedge ACLK);
        end
        BREADY = 1; nresp = 0; bq[0] = 2'bxx; bq[1] = 2'bxx;
        for (int c = 0; c < 10; c++) begin
            if (BVALID) begin
                if (nresp < 2) bq[nresp] = BRESP;
                nresp++;
            end
            @(negedge ACLK);
        end
        chk("stall_resp_count", nresp, 2);
        chk("stall_resp0", bq[0], 2'b00);
        chk("stall_resp1", bq[1], 2'b10);
        do_read(12'h008, rd, rr); chk("stall_word2", rd, mword(2));

        // reset between AW and W drops the transaction
        do_write(12'h010, 32'hA1B2C3D4, 4'hF, 0, resp);
        do_write(12'h100, 32'h1, 4'hF, 0, resp);
        aw_hs(12'h00C);
        do_reset();
        w_hs(32'h77777777, 4'hF);
        sawb = 0;
        for (int c = 0; c < 6; c++) begin sawb |= BVALID; @(negedge ACLK); end
        chk("rst_drop_no_b", sawb, 0);
        do_reset();
        for (int w = 0; w < 5; w++) begin
            do_read(12'(w * 4), rd, rr);
            chk($sformatf("rst_word%0d", w), rd, 32'h0);
        end
        chk("rst_valid_after", IMAGE_VALID, 0);

        for (int it = 0; it < 80; it++) begin
            int op, idx;
            logic [31:0] d;
            logic [3:0] s;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                idx = $urandom_range(0, 66); d = $urandom; s = 4'($urandom_range(0, 15));
                if (idx == 64 && $urandom_range(0, 1) == 1) d = d & 32'h1;
                do_write(12'(idx * 4), d, s, $urandom_range(0, 3), resp);
                chk($sformatf("rnd%0d_bresp", it), resp, mwrite(idx, d, s));
            end else if (op <= 6) begin
                idx = $urandom_range(0, 66);
                do_read(12'(idx * 4), rd, rr);
                chk($sformatf("rnd%0d_rdata", it), rd, mword(idx));
                chk($sformatf("rnd%0d_rresp", it), rr, (idx <= 64) ? 2'b00 : 2'b10);
            end else if (op <= 8) begin
                pix_chk($urandom_range(0, 255));
            end else begin
                IMAGE_ACK = 1'b1; @(negedge ACLK); IMAGE_ACK = 1'b0; mvalid = 1'b0;
                chk($sformatf("rnd%0d_ack", it), IMAGE_VALID, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_image_loader.md
AXI_IMAGE_LOADER -- requirements
Module: axi_image_loader

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, S_AXI data width; legal values 32 and 64.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 12, S_AXI byte-address width.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 8, bits per pixel; legal values 8 and 16.
REQ-004 SHALL have parameter NUM_PIXELS, default 256, image size; a multiple of PPW = AXI_DATA_WIDTH/PIXEL_WIDTH.
REQ-005 ACLK  in  1  single clock; all logic on the rising edge.
REQ-006 ARESET  in  1  reset, synchronous, active-high.
REQ-007 AWADDR  in  AXI_ADDR_WIDTH  write byte address.
REQ-008 AWPROT  in  3  ignored.
REQ-009 AWVALID / AWREADY  in / out  1  write-address handshake.
REQ-010 WDATA  in  AXI_DATA_WIDTH  write data.
REQ-011 WSTRB  in  AXI_DATA_WIDTH/8  byte strobes.
REQ-012 WVALID / WREADY  in / out  1  write-data handshake.
REQ-013 BRESP  out  2  OKAY (00) or SLVERR (10).
REQ-014 BVALID / BREADY  out / in  1  write-response handshake.
REQ-015 ARADDR  in  AXI_ADDR_WIDTH  read byte address.
REQ-016 ARPROT  in  3  ignored.
REQ-017 ARVALID / ARREADY  in / out  1  read-address handshake.
REQ-018 RDATA  out  AXI_DATA_WIDTH  read data.
REQ-019 RRESP  out  2  OKAY or SLVERR.
REQ-020 RVALID / RREADY  out / in  1  read-data handshake.
REQ-021 PIX_ADDR  in  clog2(NUM_PIXELS)  core-side pixel index.
REQ-022 PIX_DATA  out  PIXEL_WIDTH  registered pixel value.
REQ-023 IMAGE_VALID  out  1  committed image is ready for the SNN core.
REQ-024 IMAGE_ACK  in  1  single-cycle pulse: core has consumed the image.

Function
REQ-025 Address decode SHALL use word index = addr >> clog2(AXI_DATA_WIDTH/8); NUM_WORDS = NUM_PIXELS/PPW.
- index < NUM_WORDS: pixel word.
- index == NUM_WORDS: CTRL register.
- any other index: invalid.
REQ-026 Pixel p SHALL reside in word p/PPW, bits [(p%PPW)*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-027 AW and W SHALL be accepted independently, each into a one-entry holding register; AWREADY/WREADY SHALL be high only while the corresponding register is empty.
REQ-028 A write SHALL execute on the first edge at which both holding registers are full and (!BVALID || BREADY).
- That edge empties both holding registers and sets BVALID.
- Minimum latency: handshake at edge k, BVALID high after edge k+1.
REQ-029 Pixel-word writes SHALL update only the bytes whose WSTRB bit is set; all other bytes SHALL retain their value.
REQ-030 A pixel-word write while IMAGE_VALID=1 SHALL be discarded with BRESP=SLVERR.
REQ-031 A write to an invalid index SHALL change no state and SHALL return BRESP=SLVERR.
REQ-032 CTRL write effects, each applied only when WSTRB[0]=1:
- WDATA[0]=1 (COMMIT): sets IMAGE_VALID; OKAY; no effect if IMAGE_VALID is already 1.
- WDATA[1]=1 (CLEAR): zeroes all pixels in one cycle; SLVERR and no effect if IMAGE_VALID=1.
- COMMIT and CLEAR together: clear first, then commit.
REQ-033 IMAGE_ACK while IMAGE_VALID=1 SHALL clear IMAGE_VALID at the next edge; IMAGE_ACK while IMAGE_VALID=0 SHALL be ignored.
REQ-034 When IMAGE_ACK and a COMMIT execute on the same edge, IMAGE_ACK SHALL win, leaving IMAGE_VALID=0.
REQ-035 ARREADY SHALL be high only while RVALID=0.
- On AR handshake, RDATA/RRESP SHALL be registered and RVALID set at the same edge.
- RDATA/RRESP SHALL be held stable until RREADY.
REQ-036 Read data by target:
- Pixel word: stored word.
- CTRL: {zeros, IMAGE_VALID} in bit 0.
- Invalid index: RDATA=0, RRESP=SLVERR.
REQ-037 Reads and writes SHALL proceed concurrently; a read of a word written on the same edge SHALL return the pre-write value.
REQ-038 PIX_DATA SHALL equal pixel[PIX_ADDR] one cycle after PIX_ADDR is presented.

Reset
REQ-039 While ARESET=1, at the next edge the block SHALL set:
- pixels = 0; IMAGE_VALID = 0; PIX_DATA = 0;
- BVALID = RVALID = 0; BRESP = RRESP = 00; RDATA = 0;
- holding registers empty; AWREADY = WREADY = ARREADY = 0.
REQ-040 AWREADY, WREADY and ARREADY SHALL rise the first cycle after ARESET falls; a transaction in flight when reset asserts SHALL be dropped without a response.

Verification
REQ-041 Write AW 0x004 then W 0xDDCCBBAA (STRB 1111) three cycles later -> BVALID/OKAY; PIX_ADDR 4..7 returns AA, BB, CC, DD.
REQ-042 Write 0x004 with WDATA 0x11223344, STRB 0101 -> word 1 reads 0xDD22BB44.
REQ-043 CTRL (0x100) write 0x1 -> IMAGE_VALID=1; then pixel write -> SLVERR, data unchanged; then IMAGE_ACK pulse -> IMAGE_VALID=0.
REQ-044 Write and read 0x104 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0; CTRL write 0x2 with IMAGE_VALID=0 -> all pixels read 0.
REQ-045 BREADY held low for 5 cycles with AW/W presented back-to-back -> second write does not execute and AWREADY/WREADY stay low until BREADY; no response lost.
REQ-046 ARESET asserted between AW and W handshakes -> no BVALID; after release, buffer reads 0 and IMAGE_VALID=0.
